// File: rtl/phasecalc_pkg.sv
// rtl/phasecalc_pkg.sv - shared constants, arctangent table and FSM encoding for phasecalc_mc
package phasecalc_pkg;

  // Table scale: entries are degrees * 2^TAB_FRAC
  localparam int TAB_FRAC = 10;

  // atan(2^-i) in degrees * 1024, rounded, i = 0..19
  localparam int ATAN_TAB [0:19] = '{
    46080, 27203, 14373, 7296, 3662, 1833, 917, 458, 229, 115,
    57, 29, 14, 7, 4, 2, 1, 0, 0, 0
  };

  localparam int DEG180 = 180 << TAB_FRAC;
  localparam int DEG360 = 360 << TAB_FRAC;

  // Fractional guard bits below the input LSB so late micro-rotations still act on small vectors
  localparam int GUARD = 6;

  // Micro-rotation index width (covers up to 20 iterations)
  localparam int IW = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_ITER = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/cordic_vec_step.sv
// rtl/cordic_vec_step.sv - one combinational vectoring-mode CORDIC micro-rotation
module cordic_vec_step
  import phasecalc_pkg::*;
#(
  parameter int XW    = 21,
  parameter int ZW    = 21,
  parameter int AFRAC = 10
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic signed [ZW-1:0] z,
  input  logic        [IW-1:0] i,
  output logic signed [XW-1:0] xo,
  output logic signed [XW-1:0] yo,
  output logic signed [ZW-1:0] zo
);

  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;
  logic signed [ZW-1:0] a;

  // Rotate toward the positive x axis; z accumulates the angle rotated away
  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    a  = ZW'(ATAN_TAB[i] >>> (TAB_FRAC - AFRAC));
    if (y < 0) begin
      xo = x - ys;
      yo = y + xs;
      zo = z - a;
    end else begin
      xo = x + ys;
      yo = y - xs;
      zo = z + a;
    end
  end

endmodule

// File: rtl/phasecalc_mc.sv
// rtl/phasecalc_mc.sv - multi-channel iterative CORDIC phase calculator with optional relative mode
module phasecalc_mc
  import phasecalc_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int DW    = 13,
  parameter  int AW    = 19,
  parameter  int AFRAC = 10,
  parameter  int NITER = 16,
  localparam int CW    = $clog2(NCH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  data_rdy,
  input  logic [NCH*DW-1:0]     x_in,
  input  logic [NCH*DW-1:0]     y_in,
  input  logic                  rel_mode,
  output logic                  busy,
  output logic signed [AW-1:0]  angle,
  output logic [CW-1:0]         angle_ch,
  output logic                  angle_vld,
  output logic                  zero_vec,
  output logic                  done,
  output logic                  overrun
);

  // Two bits of integer headroom for CORDIC gain and negation of the most negative input
  localparam int XW = DW + 2 + GUARD;
  localparam int ZW = AW + 2;

  localparam logic signed [ZW-1:0] D180Z = ZW'(DEG180 >>> (TAB_FRAC - AFRAC));
  localparam logic signed [AW:0]   D180W = (AW+1)'(DEG180 >>> (TAB_FRAC - AFRAC));
  localparam logic signed [AW:0]   D360W = (AW+1)'(DEG360 >>> (TAB_FRAC - AFRAC));

  state_t state_q, state_d;
  logic   cap_en, load_en, iter_en, out_en;

  logic signed [DW-1:0] cx [NCH];
  logic signed [DW-1:0] cy [NCH];
  logic                 rel_q;
  logic [CW-1:0]        ch_q;
  logic [IW-1:0]        it_q;
  logic signed [XW-1:0] xr, yr, xn, yn, xl, yl;
  logic signed [ZW-1:0] zr, zn, zl;
  logic                 zf_q, zf_l;
  logic signed [AW-1:0] ang0_q;
  logic                 z0_q;

  logic                 accept, last_it, last_ch;
  logic signed [AW-1:0] abs_ang, res;
  logic signed [AW:0]   diff;
  logic                 zq;

  assign accept  = data_rdy && !busy;
  assign last_it = (it_q == IW'(NITER - 1));
  assign last_ch = (ch_q == CW'(NCH - 1));
  assign abs_ang = zr[AW-1:0];

  cordic_vec_step #(.XW(XW), .ZW(ZW), .AFRAC(AFRAC)) u_step (
    .x  (xr),
    .y  (yr),
    .z  (zr),
    .i  (it_q),
    .xo (xn),
    .yo (yn),
    .zo (zn)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: capture, pre-rotate, iterate, emit, then next channel or idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_PRE;
      ST_PRE:  state_d = ST_ITER;
      ST_ITER: if (last_it) state_d = ST_OUT;
      ST_OUT:  state_d = last_ch ? ST_IDLE : ST_PRE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath enables decoded from the current state
  always_comb begin
    cap_en  = (state_q == ST_IDLE) && accept;
    load_en = (state_q == ST_PRE);
    iter_en = (state_q == ST_ITER);
    out_en  = (state_q == ST_OUT);
  end

  // Pre-rotation: fold left half-plane vectors into the right half-plane, seeding z with +/-180
  always_comb begin
    xl   = XW'(cx[ch_q]);
    yl   = XW'(cy[ch_q]);
    xl   = xl <<< GUARD;
    yl   = yl <<< GUARD;
    zl   = '0;
    zf_l = (cx[ch_q] == '0) && (cy[ch_q] == '0);
    if (xl < 0) begin
      xl = -xl;
      yl = -yl;
      zl = (cy[ch_q] >= 0) ? D180Z : -D180Z;
    end
  end

  // Result selection: absolute angle, or difference to channel 0 wrapped into (-180,180]
  always_comb begin
    diff = {abs_ang[AW-1], abs_ang} - {ang0_q[AW-1], ang0_q};
    if (diff > D180W)        diff = diff - D360W;
    else if (diff <= -D180W) diff = diff + D360W;
    zq  = zf_q || (rel_q && (ch_q != '0) && z0_q);
    if (zq)                          res = '0;
    else if (rel_q && (ch_q != '0))  res = diff[AW-1:0];
    else                             res = abs_ang;
  end

  // Capture, CORDIC registers, channel sequencing and output strobes
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        cx[c] <= '0;
        cy[c] <= '0;
      end
      rel_q     <= 1'b0;
      ch_q      <= '0;
      it_q      <= '0;
      xr        <= '0;
      yr        <= '0;
      zr        <= '0;
      zf_q      <= 1'b0;
      ang0_q    <= '0;
      z0_q      <= 1'b0;
      busy      <= 1'b0;
      angle     <= '0;
      angle_ch  <= '0;
      angle_vld <= 1'b0;
      zero_vec  <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      angle_vld <= 1'b0;
      done      <= 1'b0;
      busy      <= (state_d != ST_IDLE) || (state_q == ST_OUT);
      if (cap_en) begin
        for (int c = 0; c < NCH; c++) begin
          cx[c] <= x_in[c*DW +: DW];
          cy[c] <= y_in[c*DW +: DW];
        end
        rel_q   <= rel_mode;
        ch_q    <= '0;
        overrun <= 1'b0;
      end else if (data_rdy && busy) begin
        overrun <= 1'b1;
      end
      if (load_en) begin
        xr   <= xl;
        yr   <= yl;
        zr   <= zl;
        zf_q <= zf_l;
        it_q <= '0;
      end
      if (iter_en) begin
        xr   <= xn;
        yr   <= yn;
        zr   <= zn;
        it_q <= it_q + 1'b1;
      end
      if (out_en) begin
        angle     <= res;
        angle_ch  <= ch_q;
        angle_vld <= 1'b1;
        zero_vec  <= zq;
        if (ch_q == '0) begin
          ang0_q <= abs_ang;
          z0_q   <= zf_q;
        end
        if (last_ch) done <= 1'b1;
        else         ch_q <= ch_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phasecalc_mc.sv
// tb/tb_phasecalc_mc.sv - table-driven self-checking bench for phasecalc_mc
module tb_phasecalc_mc;

  localparam int NCH   = 4;
  localparam int DW    = 13;
  localparam int AW    = 19;
  localparam int AFRAC = 10;
  localparam int NITER = 16;
  localparam int LAT   = NITER + 2;
  localparam int TOL   = 102;
  localparam int NCYC  = 80;
  localparam real PI   = 3.14159265358979;

  typedef struct packed {
    logic                   rel;
    logic [NCH-1:0][DW-1:0] x;
    logic [NCH-1:0][DW-1:0] y;
    logic [NCH-1:0][31:0]   ang;
    logic [NCH-1:0]         zv;
  } vec_t;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  data_rdy;
  logic [NCH*DW-1:0]     x_in;
  logic [NCH*DW-1:0]     y_in;
  logic                  rel_mode;
  logic                  busy;
  logic signed [AW-1:0]  angle;
  logic [1:0]            angle_ch;
  logic                  angle_vld;
  logic                  zero_vec;
  logic                  done;
  logic                  overrun;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_vld, n_done, done_t;
  int   got_ch  [8];
  int   got_ang [8];
  int   got_zv  [8];
  int   got_t   [8];
  logic busy_log [0:255];
  logic ovr_log  [0:255];
  vec_t tab [7];

  always #5 clock = ~clock;

  phasecalc_mc #(
    .NCH(NCH), .DW(DW), .AW(AW), .AFRAC(AFRAC), .NITER(NITER)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .data_rdy  (data_rdy),
    .x_in      (x_in),
    .y_in      (y_in),
    .rel_mode  (rel_mode),
    .busy      (busy),
    .angle     (angle),
    .angle_ch  (angle_ch),
    .angle_vld (angle_vld),
    .zero_vec  (zero_vec),
    .done      (done),
    .overrun   (overrun)
  );

  task automatic check(input string name, input longint act, input longint exp, input longint tol);
    n_checks++;
    if (act > exp + tol || act < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  function automatic vec_t mk(input bit rel,
                              input int x0, input int y0, input int a0,
                              input int x1, input int y1, input int a1,
                              input int x2, input int y2, input int a2,
                              input int x3, input int y3, input int a3,
                              input logic [3:0] zv);
    vec_t r;
    r.rel    = rel;
    r.x[0]   = DW'(x0); r.y[0] = DW'(y0); r.ang[0] = a0;
    r.x[1]   = DW'(x1); r.y[1] = DW'(y1); r.ang[1] = a1;
    r.x[2]   = DW'(x2); r.y[2] = DW'(y2); r.ang[2] = a2;
    r.x[3]   = DW'(x3); r.y[3] = DW'(y3); r.ang[3] = a3;
    r.zv     = zv;
    return r;
  endfunction

  task automatic run_job(input vec_t v, input int inj_t);
    n_vld  = 0;
    n_done = 0;
    done_t = -1;
    @(negedge clock);
    x_in     = v.x;
    y_in     = v.y;
    rel_mode = v.rel;
    data_rdy = 1'b1;
    @(posedge clock); #1;
    data_rdy = 1'b0;
    x_in     = ~v.x;
    y_in     = ~v.y;
    rel_mode = ~v.rel;
    for (int t = 1; t <= NCYC; t++) begin
      @(posedge clock); #1;
      busy_log[t] = busy;
      ovr_log[t]  = overrun;
      if (angle_vld) begin
        if (n_vld < 8) begin
          got_ch[n_vld]  = int'(angle_ch);
          got_ang[n_vld] = int'(angle);
          got_zv[n_vld]  = int'(zero_vec);
          got_t[n_vld]   = t;
        end
        n_vld++;
      end
      if (done) begin
        n_done++;
        done_t = t;
      end
      data_rdy = (t == inj_t);
    end
    data_rdy = 1'b0;
  endtask

  task automatic check_job(input string name, input vec_t v);
    check({name, " vld count"}, n_vld, NCH, 0);
    check({name, " done count"}, n_done, 1, 0);
    check({name, " done cycle"}, done_t, NCH*LAT, 0);
    check({name, " busy at done"}, busy_log[NCH*LAT], 1, 0);
    check({name, " busy after done"}, busy_log[NCH*LAT+1], 0, 0);
    for (int k = 0; k < NCH && k < n_vld; k++) begin
      check($sformatf("%s ch%0d index", name, k), got_ch[k], k, 0);
      check($sformatf("%s ch%0d cycle", name, k), got_t[k], (k+1)*LAT, 0);
      check($sformatf("%s ch%0d angle", name, k), got_ang[k], int'($signed(v.ang[k])), v.zv[k] ? 0 : TOL);
      check($sformatf("%s ch%0d zero_vec", name, k), got_zv[k], int'(v.zv[k]), 0);
    end
  endtask

  initial begin
    logic [DW-1:0] pat, xv, yv;
    int            sx, sy, cnt;
    longint        e, ex;
    vec_t          v;

    tab[0] = mk(0,  1000,     0,       0,     0,  1000,  92160, -1101, -2005, -121625, -4096,     0,  184320, 4'b0000);
    tab[1] = mk(0,   500,   500,   46080,  -700,   300, 160565,     0,     0,       0,     0, -1000,  -92160, 4'b0100);
    tab[2] = mk(1, -1000,  -100, -178473, -1000,   100, -11695, -1000,  -100,       0,  1000,     0,  178473, 4'b0000);
    tab[3] = mk(1, -1000,   100,  178473, -1000,  -100,  11695,  1000,     0, -178473,     0,  1000,  -86313, 4'b0000);
    tab[4] = mk(1,     0,     0,       0,  1000,  1000,      0,    -3,     5,       0,     7,    -9,       0, 4'b1111);
    tab[5] = mk(0, -4096, -4096, -138240,  4095,  4095,  46080, -4096,  4095,  138247, -4096,    -1, -184306, 4'b0000);
    tab[6] = mk(1,     0,  1000,   92160,  1000,     0, -92160, -1000,     0,   92160,     0,     0,       0, 4'b1000);

    reset    = 1'b1;
    data_rdy = 1'b0;
    x_in     = '0;
    y_in     = '0;
    rel_mode = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset angle", angle, 0, 0);
    check("reset angle_ch", angle_ch, 0, 0);
    check("reset angle_vld", angle_vld, 0, 0);
    check("reset zero_vec", zero_vec, 0, 0);
    check("reset done", done, 0, 0);
    check("reset busy", busy, 0, 0);
    check("reset overrun", overrun, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int j = 0; j < 7; j++) begin
      run_job(tab[j], 0);
      check_job($sformatf("vec%0d", j), tab[j]);
    end

    // Overrun: second strobe 10 cycles into a job is ignored and flagged
    run_job(tab[0], 10);
    check_job("overrun job", tab[0]);
    check("overrun set", ovr_log[11], 1, 0);
    check("overrun sticky", ovr_log[NCYC], 1, 0);
    run_job(tab[2], 0);
    check_job("after overrun", tab[2]);
    check("overrun cleared", ovr_log[1], 0, 0);

    // Reset in the middle of a job
    @(negedge clock);
    x_in     = tab[0].x;
    y_in     = tab[0].y;
    rel_mode = 1'b0;
    data_rdy = 1'b1;
    @(posedge clock); #1;
    data_rdy = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midreset angle", angle, 0, 0);
    check("midreset angle_ch", angle_ch, 0, 0);
    check("midreset angle_vld", angle_vld, 0, 0);
    check("midreset zero_vec", zero_vec, 0, 0);
    check("midreset done", done, 0, 0);
    check("midreset busy", busy, 0, 0);
    cnt = 0;
    for (int t = 0; t < 120; t++) begin
      @(posedge clock); #1;
      if (angle_vld || done) cnt++;
    end
    check("midreset no strobes", cnt, 0, 0);
    run_job(tab[1], 0);
    check_job("post-reset", tab[1]);

    // Bit-walk sweep, same vector on all channels, against an atan2 reference
    pat = 13'b1100000000000;
    for (int kx = 0; kx < DW; kx++) begin
      for (int ky = 0; ky < DW; ky++) begin
        xv = pat >> kx;
        yv = pat >> ky;
        sx = int'($signed(xv));
        sy = int'($signed(yv));
        if ((sx < 256 && sx > -256) && (sy < 256 && sy > -256)) continue;
        v = '0;
        for (int c = 0; c < NCH; c++) begin
          v.x[c] = xv;
          v.y[c] = yv;
        end
        run_job(v, 0);
        e = longint'($atan2(real'(sy), real'(sx)) * 180.0 / PI * 1024.0);
        check($sformatf("sweep x=%0d y=%0d vld count", sx, sy), n_vld, NCH, 0);
        for (int k = 0; k < NCH && k < n_vld; k++) begin
          ex = e;
          if (got_ang[k] - ex > 184320) ex = ex + 368640;
          else if (got_ang[k] - ex < -184320) ex = ex - 368640;
          check($sformatf("sweep x=%0d y=%0d ch%0d angle", sx, sy, k), got_ang[k], ex, TOL);
          check($sformatf("sweep x=%0d y=%0d ch%0d zero_vec", sx, sy, k), got_zv[k], 0, 0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
